// File: rtl/bit_timer_pkg.sv
// Shared types and constants for the bit timer family.
package bit_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Smallest usable bit period; 0 and 1 both collapse to this.
  localparam int unsigned MIN_PERIOD = 1;

endpackage

// File: rtl/bit_timer_period_cnt.sv
// Per-bit clock counter: counts 1..period, reloads to MIN_PERIOD, flags mid-bit and end-of-bit.
module bit_timer_period_cnt
  import bit_timer_pkg::*;
#(
  parameter int PERIOD_W = 14
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                reload,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] half,
  output logic                sample_hit,
  output logic                period_hit
);

  logic [PERIOD_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!n_rst || reload) begin
      cnt_reg <= PERIOD_W'(MIN_PERIOD);
    end else if (en) begin
      cnt_reg <= cnt_reg + PERIOD_W'(1);
    end
  end

  assign sample_hit = (cnt_reg == half);
  assign period_hit = (cnt_reg == period);

endmodule

// File: rtl/bit_timer_flex.sv
// Bit timer: mid-bit sample, end-of-bit shift and packet-done strobes with per-packet latched timing.
module bit_timer_flex
  import bit_timer_pkg::*;
#(
  parameter int PERIOD_W = 14,
  parameter int COUNT_W  = 5
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic                resync,
  input  logic                continuous,
  input  logic [PERIOD_W-1:0] bit_period,
  input  logic [COUNT_W-1:0]  data_size,
  output logic                sample_strobe,
  output logic                shift_strobe,
  output logic                packet_done,
  output logic [COUNT_W-1:0]  bit_index,
  output logic                busy
);

  state_t              state_reg, state_next;
  logic [PERIOD_W-1:0] period_q, half_q;
  logic [COUNT_W-1:0]  bits_q, bit_cnt;
  logic [PERIOD_W-1:0] period_eff, half_raw, half_eff;
  logic                run, sample_hit, period_hit;
  logic                shift_now, done_now, start_go, relaunch, latch_now, cnt_reload;

  assign run       = (state_reg == RUN);
  assign shift_now = run && period_hit;
  // Done is decided before bit_cnt increments, so an all-ones data_size never wraps.
  assign done_now  = shift_now && (bit_cnt == bits_q);
  assign start_go  = !run && start && !abort;
  assign relaunch  = done_now && continuous && !abort;
  assign latch_now = start_go || relaunch;

  assign period_eff = (bit_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : bit_period;
  assign half_raw   = period_eff >> 1;
  assign half_eff   = (half_raw < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : half_raw;

  // Idle holds the counter at its start value so the first bit is exactly period_q long.
  assign cnt_reload = !run || abort || shift_now || resync;

  bit_timer_period_cnt #(
    .PERIOD_W(PERIOD_W)
  ) u_period_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .reload    (cnt_reload),
    .en        (run),
    .period    (period_q),
    .half      (half_q),
    .sample_hit(sample_hit),
    .period_hit(period_hit)
  );

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else if (!run) begin
      if (start) state_next = RUN;
    end else if (done_now && !continuous) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      period_q <= PERIOD_W'(MIN_PERIOD);
      half_q   <= PERIOD_W'(MIN_PERIOD);
      bits_q   <= '0;
    end else if (latch_now) begin
      period_q <= period_eff;
      half_q   <= half_eff;
      bits_q   <= data_size;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || abort) begin
      bit_cnt <= '0;
    end else if (start_go || done_now) begin
      bit_cnt <= '0;
    end else if (shift_now) begin
      bit_cnt <= bit_cnt + COUNT_W'(1);
    end
  end

  assign sample_strobe = run && sample_hit && !abort;
  assign shift_strobe  = shift_now && !abort;
  assign packet_done   = done_now && !abort;
  assign bit_index     = bit_cnt;
  assign busy          = run;

endmodule

// File: tb/tb_bit_timer_flex.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run against a cycle model.
module tb_bit_timer_flex;

  localparam int PW = 14;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          resync = 1'b0;
  logic          continuous = 1'b0;
  logic [PW-1:0] bit_period = '0;
  logic [CW-1:0] data_size = '0;
  logic          sample_strobe, shift_strobe, packet_done, busy;
  logic [CW-1:0] bit_index;

  always #5 clk = ~clk;

  bit_timer_flex #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .resync       (resync),
    .continuous   (continuous),
    .bit_period   (bit_period),
    .data_size    (data_size),
    .sample_strobe(sample_strobe),
    .shift_strobe (shift_strobe),
    .packet_done  (packet_done),
    .bit_index    (bit_index),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_run = 1'b0;
  int m_period = 1, m_half = 1, m_bits = 0, m_pos = 1, m_bit = 0;

  function automatic int eff_period(input int p);
    return (p < 1) ? 1 : p;
  endfunction

  function automatic int eff_half(input int p);
    int h;
    h = eff_period(p) / 2;
    return (h < 1) ? 1 : h;
  endfunction

  always @(posedge clk) begin
    if (!n_rst) begin
      m_run <= 1'b0; m_period <= 1; m_half <= 1; m_bits <= 0; m_pos <= 1; m_bit <= 0;
    end else if (abort) begin
      m_run <= 1'b0; m_pos <= 1; m_bit <= 0;
    end else if (!m_run) begin
      if (start) begin
        m_run <= 1'b1; m_pos <= 1; m_bit <= 0;
        m_period <= eff_period(int'(bit_period));
        m_half   <= eff_half(int'(bit_period));
        m_bits   <= int'(data_size);
      end
    end else if (m_pos == m_period && m_bit == m_bits) begin
      m_pos <= 1; m_bit <= 0;
      if (continuous) begin
        m_period <= eff_period(int'(bit_period));
        m_half   <= eff_half(int'(bit_period));
        m_bits   <= int'(data_size);
      end else begin
        m_run <= 1'b0;
      end
    end else if (m_pos == m_period) begin
      m_bit <= m_bit + 1; m_pos <= 1;
    end else begin
      m_pos <= resync ? 1 : m_pos + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_s, e_sh, e_d;
      logic [CW-1:0] e_idx;
      e_s   = m_run && !abort && (m_pos == m_half);
      e_sh  = m_run && !abort && (m_pos == m_period);
      e_d   = e_sh && (m_bit == m_bits);
      e_idx = CW'(m_bit);
      check("model", 16'({sample_strobe, shift_strobe, packet_done, busy, bit_index}),
                     16'({e_s, e_sh, e_d, m_run, e_idx}));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int k, input logic s, input logic sh,
                     input logic d, input logic b, input int idx);
    check($sformatf("%s_strb@%0d", name, k),
          16'({sample_strobe, shift_strobe, packet_done, busy}), 16'({s, sh, d, b}));
    check($sformatf("%s_idx@%0d", name, k), 16'(bit_index), 16'(idx));
  endtask

  task automatic go_idle();
    abort = 1'b1; resync = 1'b0; continuous = 1'b0; start = 1'b0;
    tick();
    abort = 1'b0;
    tick();
  endtask

  initial begin
    // reset
    tick(); tick();
    lit("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    n_rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // D1: bit_period=10, data_size=7
    bit_period = 10; data_size = 7; start = 1'b1;
    for (int k = 1; k <= 81; k++) begin
      tick(); start = 1'b0; #1;
      lit("d1", k, (k <= 80) && (k % 10 == 5), (k <= 80) && (k % 10 == 0), k == 80,
          k <= 80, (k <= 80) ? (k - 1) / 10 : 0);
    end
    go_idle();

    // D2: continuous, data_size changes mid-packet
    bit_period = 4; data_size = 1; continuous = 1'b1; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick(); start = 1'b0;
      if (k == 3) data_size = 2;
      if (k == 10) continuous = 1'b0;
      #1;
      lit("d2", k, (k <= 20) && (k % 4 == 2), (k <= 20) && (k % 4 == 0), (k == 8) || (k == 20),
          k <= 20, (k <= 8) ? (k - 1) / 4 : ((k <= 20) ? (k - 9) / 4 : 0));
    end
    go_idle();

    // D3: bit_period=0 behaves as 1
    bit_period = 0; data_size = 3; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(); start = 1'b0; #1;
      lit("d3", k, k <= 4, k <= 4, k == 4, k <= 4, (k <= 4) ? k - 1 : 0);
    end
    go_idle();

    // D4: resync at cycle 13 of bit_period=8
    bit_period = 8; data_size = 7; start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      tick(); start = 1'b0; resync = (k == 13); #1;
      lit("d4", k, (k == 4) || (k == 12) || (k == 17), (k == 8) || (k == 21), 1'b0, 1'b1,
          (k <= 8) ? 0 : 1);
    end
    go_idle();

    // D5: abort at cycle 12, restart at 14
    bit_period = 10; data_size = 7; start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick(); start = 1'b0; abort = (k == 12); #1;
      if (k <= 11)       lit("d5", k, k == 5, k == 10, 1'b0, 1'b1, (k - 1) / 10);
      else if (k == 12)  lit("d5", k, 1'b0, 1'b0, 1'b0, 1'b1, 1);
      else if (k <= 14)  lit("d5", k, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      else               lit("d5", k, k == 19, k == 24, 1'b0, 1'b1, 0);
      if (k == 14) start = 1'b1;
    end
    go_idle();

    // D6: reset mid-packet, then a fresh packet
    bit_period = 6; data_size = 3; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(); start = 1'b0;
    end
    n_rst = 1'b0;
    tick(); n_rst = 1'b1; #1;
    lit("d6rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    bit_period = 3; data_size = 0; start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(); start = 1'b0; #1;
      lit("d6", k, k == 1, k == 3, k == 3, k <= 3, 0);
    end
    go_idle();

    // D7: all-ones data_size gives 32 bits without wrap
    bit_period = 1; data_size = 31; start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick(); start = 1'b0; #1;
      lit("d7", k, k <= 32, k <= 32, k == 32, k <= 32, (k <= 32) ? k - 1 : 0);
    end
    go_idle();

    // Randomized run, checked every cycle by the model compare process
    for (int i = 0; i < 4000; i++) begin
      tick();
      n_rst  = ($urandom_range(0, 399) != 0);
      start  = ($urandom_range(0, 5) == 0);
      abort  = ($urandom_range(0, 49) == 0);
      resync = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 99) == 0) continuous = ~continuous;
      if ($urandom_range(0, 19) == 0) bit_period = PW'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) data_size = CW'($urandom_range(0, 31));
    end
    n_rst = 1'b1;
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
